// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle floating-point adder/subtractor with start/busy/done handshake,
// guard bits during align/add, truncating normalisation and IEEE-style special values.
module fp_add_seq #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int GRD_W = 2
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_zero,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_nan
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + GRD_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, MAN_W'(1) << (MAN_W - 1)};

    typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ADD, NORM, DONE} state_t;

    state_t           r_state;
    logic [W-1:0]     r_a, r_b;
    logic             r_sub, r_spec, r_sg, r_sl;
    logic [EXP_W-1:0] r_e, r_diff;
    logic [MW-1:0]    r_mg, r_ml;

    logic             w_sa, w_sb, w_swap;
    logic [EXP_W-1:0] w_ea, w_eb, w_einc, w_edec;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    assign w_sa     = r_a[W-1];
    assign w_sb     = r_b[W-1] ^ r_sub;
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_a_nan  = (w_ea == EMAX) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EMAX) && (w_fb != '0);
    assign w_a_inf  = (w_ea == EMAX) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EMAX) && (w_fb == '0);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_swap   = r_b[W-2:0] > r_a[W-2:0];
    assign w_einc   = r_e + EXP_W'(1);
    assign w_edec   = r_e - EXP_W'(1);

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_spec    <= 1'b0;
            r_sg      <= 1'b0;
            r_sl      <= 1'b0;
            r_e       <= '0;
            r_diff    <= '0;
            r_mg      <= '0;
            r_ml      <= '0;
            result    <= '0;
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_nan  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a       <= a;
                    r_b       <= b;
                    r_sub     <= op_sub;
                    flag_zero <= 1'b0;
                    flag_ovf  <= 1'b0;
                    flag_unf  <= 1'b0;
                    flag_nan  <= 1'b0;
                    r_state   <= LOAD;
                end
                LOAD: begin
                    // special results are final here but leave via ALIGN to keep a fixed 2-edge latency
                    r_state <= ALIGN;
                    r_spec  <= 1'b1;
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
                        result   <= QNAN;
                        flag_nan <= 1'b1;
                    end else if (w_a_inf) begin
                        result <= {w_sa, EMAX, MAN_W'(0)};
                    end else if (w_b_inf) begin
                        result <= {w_sb, EMAX, MAN_W'(0)};
                    end else if (w_a_zero && w_b_zero) begin
                        result    <= '0;
                        flag_zero <= 1'b1;
                    end else if (w_a_zero) begin
                        result <= {w_sb, r_b[W-2:0]};
                    end else if (w_b_zero) begin
                        result <= r_a;
                    end else begin
                        r_spec <= 1'b0;
                        r_sg   <= w_swap ? w_sb : w_sa;
                        r_sl   <= w_swap ? w_sa : w_sb;
                        r_e    <= w_swap ? w_eb : w_ea;
                        r_diff <= w_swap ? w_eb - w_ea : w_ea - w_eb;
                        r_mg   <= {2'b01, w_swap ? w_fb : w_fa, {GRD_W{1'b0}}};
                        r_ml   <= {2'b01, w_swap ? w_fa : w_fb, {GRD_W{1'b0}}};
                    end
                end
                ALIGN: begin
                    r_ml    <= r_ml >> r_diff;
                    r_state <= r_spec ? DONE : ADD;
                end
                ADD: begin
                    r_mg    <= (r_sg == r_sl) ? r_mg + r_ml : r_mg - r_ml;
                    r_state <= NORM;
                end
                NORM: begin
                    if (r_mg == '0) begin
                        result    <= '0;
                        flag_zero <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_mg[MW-1]) begin
                        r_mg <= r_mg >> 1;
                        r_e  <= w_einc;
                        if (w_einc == EMAX) begin
                            result   <= {r_sg, EMAX, MAN_W'(0)};
                            flag_ovf <= 1'b1;
                            r_state  <= DONE;
                        end
                    end else if (!r_mg[MW-2]) begin
                        r_mg <= r_mg << 1;
                        r_e  <= w_edec;
                        if (w_edec == '0) begin
                            result    <= '0;
                            flag_unf  <= 1'b1;
                            flag_zero <= 1'b1;
                            r_state   <= DONE;
                        end
                    end else begin
                        result  <= {r_sg, r_e, r_mg[MW-3 -: MAN_W]};
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed and randomized checks of fp_add_seq against an integer-arithmetic
// reference model of the add/subtract, truncation, special-value and latency rules.
module tb_fp_add_seq;
    localparam int EW = 4, MN = 3, G = 2, W = 1 + EW + MN;

    logic clk = 1'b0;
    logic clr, start, op_sub;
    logic [W-1:0] a, b, result;
    logic busy, done, flag_zero, flag_ovf, flag_unf, flag_nan;
    int n_vec = 0, n_err = 0;
    int first, second, cnt;

    fp_add_seq #(.EXP_W(EW), .MAN_W(MN), .GRD_W(G)) u_dut (
        .clk(clk), .clr(clr), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flag_zero(flag_zero),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_nan(flag_nan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // value-level model: magnitudes as integers scaled by 2^G, guard bits lost on alignment
    function automatic void ref_add(input logic [7:0] x, input logic [7:0] y, input logic sub,
                                    output logic [7:0] r, output logic [3:0] f, output int lat);
        bit sx, sy, sg, sl, nx, ny, ix, iy, zx, zy, sw;
        int ex, ey, eg, el, mg, ml, n, p, e, fr;
        sx = x[7];
        sy = y[7] ^ sub;
        ex = int'(x[6:3]);
        ey = int'(y[6:3]);
        nx = (ex == 15) && (x[2:0] != 3'd0);
        ny = (ey == 15) && (y[2:0] != 3'd0);
        ix = (ex == 15) && (x[2:0] == 3'd0);
        iy = (ey == 15) && (y[2:0] == 3'd0);
        zx = (ex == 0);
        zy = (ey == 0);
        f = 4'b0000;
        lat = 2;
        if (nx || ny || (ix && iy && (sx != sy))) begin
            r = 8'h7C;
            f = 4'b0001;
        end else if (ix) r = {sx, 7'h78};
        else if (iy) r = {sy, 7'h78};
        else if (zx && zy) begin
            r = 8'h00;
            f = 4'b1000;
        end else if (zx) r = {sy, y[6:0]};
        else if (zy) r = x;
        else begin
            sw = y[6:0] > x[6:0];
            eg = sw ? ey : ex;
            el = sw ? ex : ey;
            sg = sw ? sy : sx;
            sl = sw ? sx : sy;
            mg = (8 + int'(sw ? y[2:0] : x[2:0])) << G;
            ml = ((8 + int'(sw ? x[2:0] : y[2:0])) << G) >> (eg - el);
            n = (sg == sl) ? mg + ml : mg - ml;
            lat = 4;
            if (n == 0) begin
                r = 8'h00;
                f = 4'b1000;
            end else begin
                p = 0;
                while ((n >> (p + 1)) != 0) p++;
                e = eg + p - (MN + G);
                if (e >= 15) begin
                    r = {sg, 7'h78};
                    f = 4'b0100;
                end else if (e <= 0) begin
                    r = 8'h00;
                    f = 4'b1010;
                    lat = 3 + eg;
                end else begin
                    fr = (p >= MN) ? (n >> (p - MN)) : (n << (MN - p));
                    r = {sg, e[3:0], fr[2:0]};
                    lat = 4 + ((p > MN + G) ? p - MN - G : MN + G - p);
                end
            end
        end
    endfunction

    function automatic logic [7:0] rnd_op(input int near_e);
        int k, e;
        k = int'($urandom_range(0, 19));
        e = (k == 0) ? 0 : (k == 1) ? 15 : (near_e > 0 && k < 12) ? near_e : int'($urandom_range(1, 14));
        return {1'($urandom), 4'(e), 3'($urandom)};
    endfunction

    // lat = edges after the accepting edge until done is seen; -1 if the bound expires
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          output logic [7:0] r, output logic [3:0] f, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        a = x;
        b = y;
        op_sub = s;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op_sub = 1'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = -1;
        while (n < 40 && lat < 0) begin
            if (done) lat = n;
            else begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end
        r = result;
        f = {flag_zero, flag_ovf, flag_unf, flag_nan};
        @(negedge clk);
        chk("done_one_cycle", 32'({done, busy}), 32'd0);
    endtask

    task automatic dir(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [7:0] er, input logic [3:0] ef, input int el);
        logic [7:0] r;
        logic [3:0] f;
        int lat;
        run_op(x, y, s, r, f, lat);
        chk({tag, "_res"}, 32'(r), 32'(er));
        chk({tag, "_flg"}, 32'(f), 32'(ef));
        chk({tag, "_lat"}, lat, el);
    endtask

    initial begin
        logic [7:0] x, y, er, gr;
        logic [3:0] ef, gf;
        logic s;
        int el, gl, near_e;
        clr = 1'b1;
        start = 1'b0;
        op_sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_zero, flag_ovf, flag_unf, flag_nan}), 32'd0);
        clr = 1'b0;

        dir("one_plus_one",  8'h38, 8'h38, 1'b0, 8'h40, 4'b0000, 5);
        dir("sub_cancel2",   8'h3C, 8'h3A, 1'b1, 8'h28, 4'b0000, 6);
        dir("align3",        8'h38, 8'h20, 1'b0, 8'h39, 4'b0000, 4);
        dir("exact_zero",    8'h38, 8'h38, 1'b1, 8'h00, 4'b1000, 4);
        dir("overflow",      8'h77, 8'h77, 1'b0, 8'h78, 4'b0100, 4);
        dir("underflow",     8'h0C, 8'h08, 1'b1, 8'h00, 4'b1010, 4);
        dir("inf_minus_inf", 8'h78, 8'h78, 1'b1, 8'h7C, 4'b0001, 2);
        dir("nan_in",        8'h79, 8'h38, 1'b0, 8'h7C, 4'b0001, 2);
        dir("zero_a",        8'h00, 8'hB8, 1'b0, 8'hB8, 4'b0000, 2);
        dir("zero_b",        8'h38, 8'h00, 1'b1, 8'h38, 4'b0000, 2);
        dir("inf_b_sub",     8'h38, 8'h78, 1'b1, 8'hF8, 4'b0000, 2);
        dir("neg_cancel",    8'hB8, 8'h38, 1'b0, 8'h00, 4'b1000, 4);
        dir("swap_sub",      8'h20, 8'h38, 1'b1, 8'hB6, 4'b0000, 5);

        // start held high: one operation per IDLE visit, 7 edges apart for 1+1
        @(negedge clk);
        a = 8'h38;
        b = 8'h38;
        op_sub = 1'b0;
        start = 1'b1;
        first = -1;
        second = -1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                cnt++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
                chk("hold_res", 32'(result), 32'h40);
            end
        end
        start = 1'b0;
        chk("hold_first_done", first, 5);
        chk("hold_second_done", second, 12);
        chk("hold_done_count", cnt, 4);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("hold_idle", 32'(busy), 32'd0);

        // clr while normalising discards the operation and the previous result
        dir("pre_clr", 8'h38, 8'h38, 1'b0, 8'h40, 4'b0000, 5);
        @(negedge clk);
        a = 8'h3C;
        b = 8'h3A;
        op_sub = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_result", 32'(result), 32'd0);
        chk("clr_flags", 32'({flag_zero, flag_ovf, flag_unf, flag_nan}), 32'd0);
        dir("post_clr", 8'h38, 8'h20, 1'b0, 8'h39, 4'b0000, 4);

        for (int i = 0; i < 300; i++) begin
            x = rnd_op(0);
            near_e = int'(x[6:3]) + int'($urandom_range(0, 2)) - 1;
            near_e = (near_e < 1) ? 1 : (near_e > 14) ? 14 : near_e;
            y = rnd_op(near_e);
            s = 1'($urandom);
            ref_add(x, y, s, er, ef, el);
            run_op(x, y, s, gr, gf, gl);
            chk($sformatf("rnd%0d_res %h%s%h", i, x, s ? "-" : "+", y), 32'(gr), 32'(er));
            chk($sformatf("rnd%0d_flg %h%s%h", i, x, s ? "-" : "+", y), 32'(gf), 32'(ef));
            chk($sformatf("rnd%0d_lat %h%s%h", i, x, s ? "-" : "+", y), gl, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
